// File: rtl/vram_arbiter.sv
// Two-requester arbiter for the shared cartridge/VRAM bus: render fetch has
// priority, host is guaranteed a slot after G_starve_limit consecutive fetches.
//
// state  | meaning
// IDLE   | bus free; pick a winner and launch its address
// ADDR   | address (and host write strobe) on the bus; read data captured at end
// DATA   | winner's ack pulses; bus address held
module vram_arbiter #(
    parameter int G_starve_limit = 8
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_fetch_req,
    input  logic [13:0] I_fetch_addr,
    output logic        O_fetch_ack,
    output logic [7:0]  O_fetch_data,
    input  logic        I_host_req,
    input  logic        I_host_wren,
    input  logic [13:0] I_host_addr,
    input  logic [7:0]  I_host_data,
    output logic        O_host_ack,
    output logic [7:0]  O_host_data,
    output logic [13:0] O_cart_addr,
    output logic        O_cart_wren,
    output logic [7:0]  O_cart_data,
    input  logic [7:0]  I_cart_data,
    output logic        O_busy
);

    localparam int                 C_cnt_w = $clog2(G_starve_limit + 1);
    localparam logic [C_cnt_w-1:0] C_limit = C_cnt_w'(G_starve_limit);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t             state;
    logic               winner_host;
    logic [C_cnt_w-1:0] starve_cnt;
    logic               host_win;

    // Host takes the slot when fetch is absent or fetch has used up its run.
    assign host_win = I_host_req && (!I_fetch_req || (starve_cnt == C_limit));

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state        <= S_IDLE;
            winner_host  <= 1'b0;
            starve_cnt   <= '0;
            O_fetch_ack  <= 1'b0;
            O_fetch_data <= 8'h00;
            O_host_ack   <= 1'b0;
            O_host_data  <= 8'h00;
            O_cart_addr  <= 14'h0000;
            O_cart_wren  <= 1'b0;
            O_cart_data  <= 8'h00;
            O_busy       <= 1'b0;
        end else begin
            O_fetch_ack <= 1'b0;
            O_host_ack  <= 1'b0;
            O_cart_wren <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host_win) begin
                        winner_host <= 1'b1;
                        O_cart_addr <= I_host_addr;
                        O_cart_data <= I_host_data;
                        O_cart_wren <= I_host_wren;
                        starve_cnt  <= '0;
                        O_busy      <= 1'b1;
                        state       <= S_ADDR;
                    end else begin
                        if (!I_host_req) begin
                            starve_cnt <= '0;
                        end else if (I_fetch_req && (starve_cnt != C_limit)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        if (I_fetch_req) begin
                            winner_host <= 1'b0;
                            O_cart_addr <= I_fetch_addr;
                            O_busy      <= 1'b1;
                            state       <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    // O_cart_wren still reflects this transaction's write flag here.
                    if (winner_host) begin
                        O_host_ack <= 1'b1;
                        if (!O_cart_wren) begin
                            O_host_data <= I_cart_data;
                        end
                    end else begin
                        O_fetch_ack  <= 1'b1;
                        O_fetch_data <= I_cart_data;
                    end
                    state <= S_DATA;
                end
                S_DATA: begin
                    O_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    O_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: single reads/writes, priority, starvation
// rotation, late request drop and mid-transaction reset.
module tb_vram_arbiter;

    logic        I_clock = 1'b0;
    logic        I_reset = 1'b0;
    logic        I_fetch_req = 1'b0;
    logic [13:0] I_fetch_addr = '0;
    logic        O_fetch_ack;
    logic [7:0]  O_fetch_data;
    logic        I_host_req = 1'b0;
    logic        I_host_wren = 1'b0;
    logic [13:0] I_host_addr = '0;
    logic [7:0]  I_host_data = '0;
    logic        O_host_ack;
    logic [7:0]  O_host_data;
    logic [13:0] O_cart_addr;
    logic        O_cart_wren;
    logic [7:0]  O_cart_data;
    logic [7:0]  I_cart_data = '0;
    logic        O_busy;

    int n_vec = 0;
    int n_err = 0;

    vram_arbiter #(.G_starve_limit(8)) dut (
        .I_clock      (I_clock),
        .I_reset      (I_reset),
        .I_fetch_req  (I_fetch_req),
        .I_fetch_addr (I_fetch_addr),
        .O_fetch_ack  (O_fetch_ack),
        .O_fetch_data (O_fetch_data),
        .I_host_req   (I_host_req),
        .I_host_wren  (I_host_wren),
        .I_host_addr  (I_host_addr),
        .I_host_data  (I_host_data),
        .O_host_ack   (O_host_ack),
        .O_host_data  (O_host_data),
        .O_cart_addr  (O_cart_addr),
        .O_cart_wren  (O_cart_wren),
        .O_cart_data  (O_cart_data),
        .I_cart_data  (I_cart_data),
        .O_busy       (O_busy)
    );

    always #5 I_clock = ~I_clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge I_clock);
        #1;
    endtask

    // Both requesters held; host expected on every 9th transaction from phase.
    task automatic run_both(input int n_trans, input int phase);
        I_fetch_req = 1'b1;
        I_host_req  = 1'b1;
        I_host_wren = 1'b0;
        for (int t = 0; t < n_trans; t++) begin
            tick();
            check_val("rot_busy_addr", O_busy, 1);
            tick();
            check_val("rot_fetch_ack", O_fetch_ack, ((t + phase) % 9) != 8);
            check_val("rot_host_ack", O_host_ack, ((t + phase) % 9) == 8);
            if (t == n_trans - 1) begin
                I_fetch_req = 1'b0;
                I_host_req  = 1'b0;
            end
            tick();
            check_val("rot_busy_idle", O_busy, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check_val("rst_busy", O_busy, 0);
        check_val("rst_cart_addr", O_cart_addr, 0);
        check_val("rst_cart_data", O_cart_data, 0);
        check_val("rst_cart_wren", O_cart_wren, 0);
        check_val("rst_acks", {O_fetch_ack, O_host_ack}, 0);
        check_val("rst_fetch_data", O_fetch_data, 0);
        check_val("rst_host_data", O_host_data, 0);
        @(negedge I_clock);
        I_reset = 1'b1;

        // Fetch-only read
        I_fetch_req  = 1'b1;
        I_fetch_addr = 14'h1234;
        I_cart_data  = 8'hA5;
        tick();
        check_val("fr_cart_addr", O_cart_addr, 14'h1234);
        check_val("fr_busy", O_busy, 1);
        check_val("fr_wren_addr", O_cart_wren, 0);
        check_val("fr_ack_addr", O_fetch_ack, 0);
        tick();
        check_val("fr_ack", O_fetch_ack, 1);
        check_val("fr_data", O_fetch_data, 8'hA5);
        check_val("fr_wren_data", O_cart_wren, 0);
        check_val("fr_host_ack", O_host_ack, 0);
        I_fetch_req = 1'b0;
        tick();
        check_val("fr_ack_idle", O_fetch_ack, 0);
        check_val("fr_busy_idle", O_busy, 0);
        check_val("fr_addr_hold", O_cart_addr, 14'h1234);
        check_val("fr_data_hold", O_fetch_data, 8'hA5);

        // Host write
        I_host_req  = 1'b1;
        I_host_wren = 1'b1;
        I_host_addr = 14'h3F00;
        I_host_data = 8'h2C;
        I_cart_data = 8'hEE;
        tick();
        check_val("hw_wren_addr", O_cart_wren, 1);
        check_val("hw_cart_data", O_cart_data, 8'h2C);
        check_val("hw_cart_addr", O_cart_addr, 14'h3F00);
        tick();
        check_val("hw_wren_data", O_cart_wren, 0);
        check_val("hw_ack", O_host_ack, 1);
        check_val("hw_host_data", O_host_data, 8'h00);
        I_host_req = 1'b0;
        tick();
        check_val("hw_ack_idle", O_host_ack, 0);
        check_val("hw_wren_idle", O_cart_wren, 0);
        check_val("hw_cdata_hold", O_cart_data, 8'h2C);

        // Host read
        I_host_req  = 1'b1;
        I_host_wren = 1'b0;
        I_host_addr = 14'h0011;
        I_cart_data = 8'h5A;
        tick();
        check_val("hr_wren_addr", O_cart_wren, 0);
        tick();
        check_val("hr_ack", O_host_ack, 1);
        check_val("hr_data", O_host_data, 8'h5A);
        check_val("hr_fetch_data_hold", O_fetch_data, 8'hA5);
        I_host_req = 1'b0;
        tick();

        // Simultaneous requests: fetch first, host in the next slot
        I_fetch_req  = 1'b1;
        I_fetch_addr = 14'h0100;
        I_host_req   = 1'b1;
        I_host_addr  = 14'h0200;
        I_cart_data  = 8'h77;
        tick();
        check_val("sim_addr1", O_cart_addr, 14'h0100);
        tick();
        check_val("sim_fetch_ack", O_fetch_ack, 1);
        check_val("sim_host_ack0", O_host_ack, 0);
        I_fetch_req = 1'b0;
        tick();
        check_val("sim_idle_busy", O_busy, 0);
        I_cart_data = 8'h66;
        tick();
        check_val("sim_addr2", O_cart_addr, 14'h0200);
        tick();
        check_val("sim_host_ack", O_host_ack, 1);
        check_val("sim_host_data", O_host_data, 8'h66);
        check_val("sim_fetch_ack0", O_fetch_ack, 0);
        I_host_req = 1'b0;
        tick();

        // Starvation rotation: 8 fetches then 1 host, repeating
        run_both(27, 0);

        // Fetch request dropped while its transaction is in ADDR
        I_fetch_req  = 1'b1;
        I_fetch_addr = 14'h0ABC;
        I_cart_data  = 8'h3C;
        tick();
        I_fetch_req = 1'b0;
        tick();
        check_val("drop_ack", O_fetch_ack, 1);
        check_val("drop_data", O_fetch_data, 8'h3C);
        tick();
        check_val("drop_ack_off", O_fetch_ack, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("drop_no_restart", O_busy, 0);
            check_val("drop_no_ack", O_fetch_ack, 0);
        end

        // Reset during ADDR of a host write
        I_host_req  = 1'b1;
        I_host_wren = 1'b1;
        I_host_addr = 14'h1555;
        I_host_data = 8'h99;
        tick();
        check_val("rw_wren_before", O_cart_wren, 1);
        #2;
        I_reset = 1'b0;
        #1;
        check_val("rw_wren_async", O_cart_wren, 0);
        check_val("rw_busy", O_busy, 0);
        check_val("rw_cart_addr", O_cart_addr, 0);
        I_host_req  = 1'b0;
        I_host_wren = 1'b0;
        @(negedge I_clock);
        I_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rw_no_ack", {O_fetch_ack, O_host_ack}, 0);
            check_val("rw_idle", O_busy, 0);
        end

        // Reset with the starvation count part-way must restart the run of 8
        I_fetch_req = 1'b1;
        I_host_req  = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            tick();
            tick();
        end
        tick();
        #2;
        I_reset     = 1'b0;
        I_fetch_req = 1'b0;
        I_host_req  = 1'b0;
        #10;
        @(negedge I_clock);
        I_reset = 1'b1;
        run_both(18, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    always @(negedge I_clock) begin
        if (O_fetch_ack && O_host_ack)
            check_val("dual_ack", {O_fetch_ack, O_host_ack}, 2'b10);
    end

endmodule
